// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor.
// master = datapath controller, slave = subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;

  modport master (
    output start,
    output A,
    output B,
    output Bin,
    input  busy,
    input  done,
    input  Diff,
    input  Borrow
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    input  Bin,
    output busy,
    output done,
    output Diff,
    output Borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - Bin, DIGIT bits per clock, LSB slice first.
// Define SERIAL_SUB_SAT_EN to clamp Diff to 0 when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic [DIGIT-1:0] w_slice;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor chain over the current low slice of the operands.
  always_comb begin : slice_chain
    logic c;
    c       = r_brw;
    w_slice = '0;
    for (int i = 0; i < DIGIT; i++) begin
      w_slice[i] = r_a[i] ^ r_b[i] ^ c;
      c = (~r_a[i] & c)
        | (~r_a[i] & r_b[i])
        | (r_b[i] & c);
    end
    w_bout = c;
  end

  // Result bits enter at the top so the first slice ends up at bit 0.
  assign w_res_next = (r_res >> DIGIT)
                    | (WIDTH'(w_slice) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_brw    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_brw   <= bus.Bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= w_res_next;
          r_brw <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
            r_diff <= w_bout ? '0 : w_res_next;
`else
            r_diff <= w_res_next;
`endif
            r_borrow <= w_bout;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.Diff   = r_diff;
  assign bus.Borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (DIGIT 1, 4, 8) against
// an arithmetic model, plus directed literal checks.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) if0 ();
  serial_subtractor_if #(.WIDTH(W)) if1 ();
  serial_subtractor_if #(.WIDTH(W)) if2 ();

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  serial_subtractor #(.WIDTH(W), .DIGIT(8)) dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  logic         t_start [3];
  logic [W-1:0] t_a     [3];
  logic [W-1:0] t_b     [3];
  logic         t_bin   [3];
  logic         d_busy  [3];
  logic         d_done  [3];
  logic [W-1:0] d_diff  [3];
  logic         d_brw   [3];

  assign if0.start = t_start[0];
  assign if0.A     = t_a[0];
  assign if0.B     = t_b[0];
  assign if0.Bin   = t_bin[0];
  assign if1.start = t_start[1];
  assign if1.A     = t_a[1];
  assign if1.B     = t_b[1];
  assign if1.Bin   = t_bin[1];
  assign if2.start = t_start[2];
  assign if2.A     = t_a[2];
  assign if2.B     = t_b[2];
  assign if2.Bin   = t_bin[2];

  assign d_busy[0] = if0.busy;
  assign d_done[0] = if0.done;
  assign d_diff[0] = if0.Diff;
  assign d_brw[0]  = if0.Borrow;
  assign d_busy[1] = if1.busy;
  assign d_done[1] = if1.done;
  assign d_diff[1] = if1.Diff;
  assign d_brw[1]  = if1.Borrow;
  assign d_busy[2] = if2.busy;
  assign d_done[2] = if2.done;
  assign d_diff[2] = if2.Diff;
  assign d_brw[2]  = if2.Borrow;

  function automatic int ns(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [W-1:0] ex(input logic [W-1:0] v,
                                      input logic b);
`ifdef SERIAL_SUB_SAT_EN
    return b ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  // Model: 9-bit subtraction gives result and borrow; timing by countdown.
  logic         m_busy [3];
  logic         m_done [3];
  logic [W-1:0] m_diff [3];
  logic         m_brw  [3];
  int           m_left [3];
  logic [W:0]   m_pend [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_diff[k] <= '0;
        m_brw[k]  <= 1'b0;
        m_left[k] <= 0;
        m_pend[k] <= '0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (t_start[k]) begin
            m_pend[k] <= {1'b0, t_a[k]} - {1'b0, t_b[k]}
                       - (W+1)'(t_bin[k]);
            m_left[k] <= ns(k);
            m_busy[k] <= 1'b1;
          end
        end else if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_brw[k]  <= m_pend[k][W];
          m_diff[k] <= ex(m_pend[k][W-1:0], m_pend[k][W]);
        end else begin
          m_left[k] <= m_left[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        chk("m_busy", k, (W+1)'(d_busy[k]), (W+1)'(m_busy[k]));
        chk("m_done", k, (W+1)'(d_done[k]), (W+1)'(m_done[k]));
        chk("m_diff", k, (W+1)'(d_diff[k]), (W+1)'(m_diff[k]));
        chk("m_brw",  k, (W+1)'(d_brw[k]),  (W+1)'(m_brw[k]));
      end
    end
  end

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_done[k]) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("timeout", k, 0, 1);
  endtask

  task automatic run_op(input int k, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic bin,
                        output int lat);
    @(negedge clk);
    t_a[k]     = a;
    t_b[k]     = b;
    t_bin[k]   = bin;
    t_start[k] = 1'b1;
    @(negedge clk);
    t_start[k] = 1'b0;
    wait_done(k, lat);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vt [5];

  initial begin
    int lat;
    vt[0] = '{a: 8'h00, b: 8'h00, bin: 1'b0, d: 8'h00, bo: 1'b0};
    vt[1] = '{a: 8'hFF, b: 8'h00, bin: 1'b1, d: 8'hFE, bo: 1'b0};
    vt[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
    vt[3] = '{a: 8'h80, b: 8'h7F, bin: 1'b1, d: 8'h00, bo: 1'b0};
    vt[4] = '{a: 8'h3C, b: 8'hC3, bin: 1'b0, d: 8'h79, bo: 1'b1};
    for (int k = 0; k < 3; k++) begin
      t_start[k] = 1'b0;
      t_a[k]     = '0;
      t_b[k]     = '0;
      t_bin[k]   = 1'b0;
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, (W+1)'(d_busy[k]), 0);
      chk("rst_done", k, (W+1)'(d_done[k]), 0);
      chk("rst_diff", k, (W+1)'(d_diff[k]), 0);
      chk("rst_brw",  k, (W+1)'(d_brw[k]),  0);
    end
    rst = 1'b0;

    run_op(0, 8'h5A, 8'h23, 1'b0, lat);
    chk("t1_lat", 0, (W+1)'(lat), 8);
    chk("t1_diff", 0, (W+1)'(d_diff[0]), 9'h037);
    chk("t1_brw", 0, (W+1)'(d_brw[0]), 0);

    run_op(0, 8'h10, 8'h20, 1'b1, lat);
    chk("t2_diff", 0, (W+1)'(d_diff[0]), (W+1)'(ex(8'hEF, 1'b1)));
    chk("t2_brw", 0, (W+1)'(d_brw[0]), 1);

    // DIGIT=4 with start held high across two operations.
    @(negedge clk);
    t_a[1] = 8'hFF; t_b[1] = 8'hFF; t_bin[1] = 1'b1;
    t_start[1] = 1'b1;
    @(negedge clk);
    chk("t3_busy_e0", 1, (W+1)'(d_busy[1]), 1);
    @(negedge clk);
    chk("t3_busy_e1", 1, (W+1)'(d_busy[1]), 1);
    chk("t3_done_e1", 1, (W+1)'(d_done[1]), 0);
    @(negedge clk);
    chk("t3_done_e2", 1, (W+1)'(d_done[1]), 1);
    chk("t3_busy_e2", 1, (W+1)'(d_busy[1]), 0);
    chk("t3_diff", 1, (W+1)'(d_diff[1]), (W+1)'(ex(8'hFF, 1'b1)));
    chk("t3_brw", 1, (W+1)'(d_brw[1]), 1);
    t_a[1] = 8'h12; t_b[1] = 8'h01; t_bin[1] = 1'b0;
    @(negedge clk);
    chk("t3_busy_e3", 1, (W+1)'(d_busy[1]), 1);
    chk("t3_hold_e3", 1, (W+1)'(d_diff[1]), (W+1)'(ex(8'hFF, 1'b1)));
    t_start[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3b_done", 1, (W+1)'(d_done[1]), 1);
    chk("t3b_diff", 1, (W+1)'(d_diff[1]), 9'h011);
    chk("t3b_brw", 1, (W+1)'(d_brw[1]), 0);

    // Operand changes after capture must not leak in.
    @(negedge clk);
    t_a[0] = 8'h80; t_b[0] = 8'h01; t_bin[0] = 1'b0;
    t_start[0] = 1'b1;
    @(negedge clk);
    t_start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    t_a[0] = 8'h00; t_b[0] = 8'hFF; t_bin[0] = 1'b1;
    wait_done(0, lat);
    chk("t4_lat", 0, (W+1)'(lat), 6);
    chk("t4_diff", 0, (W+1)'(d_diff[0]), 9'h07F);
    chk("t4_brw", 0, (W+1)'(d_brw[0]), 0);

    // Reset mid-operation discards the result.
    @(negedge clk);
    t_a[0] = 8'h33; t_b[0] = 8'h11; t_bin[0] = 1'b0;
    t_start[0] = 1'b1;
    @(negedge clk);
    t_start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 0, (W+1)'(d_busy[0]), 0);
    chk("t5_diff", 0, (W+1)'(d_diff[0]), 0);
    chk("t5_brw", 0, (W+1)'(d_brw[0]), 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t5_nodone", 0, (W+1)'(d_done[0]), 0);
    end

    run_op(2, 8'h00, 8'h01, 1'b0, lat);
    chk("t6_lat", 2, (W+1)'(lat), 1);
    chk("t6_diff", 2, (W+1)'(d_diff[2]), (W+1)'(ex(8'hFF, 1'b1)));
    chk("t6_brw", 2, (W+1)'(d_brw[2]), 1);

    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 5; v++) begin
        run_op(k, vt[v].a, vt[v].b, vt[v].bin, lat);
        chk("tv_lat", k, (W+1)'(lat), (W+1)'(ns(k)));
        chk("tv_diff", k, (W+1)'(d_diff[k]),
            (W+1)'(ex(vt[v].d, vt[v].bo)));
        chk("tv_brw", k, (W+1)'(d_brw[k]), (W+1)'(vt[v].bo));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
